// File: rtl/dbus_xbar_n.sv
// Single-outstanding data-bus crossbar: one LSU requester fanned out to N_SLV slots
// via base/mask decode, with slot ack, timeout, decode error, flush abort and error capture.
`timescale 1ns/1ps
module dbus_xbar_n #(
    parameter int                      N_SLV    = 8,
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '1,
    parameter int                      TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    input  logic [ADDR_W-1:0]         req_addr_i,
    input  logic                      req_we_i,
    input  logic [DATA_W-1:0]         req_wdata_i,
    input  logic [DATA_W/8-1:0]       req_be_i,
    input  logic                      flush_i,
    output logic                      rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [N_SLV-1:0]          sel_o,
    output logic [ADDR_W-1:0]         peri_addr_o,
    output logic                      peri_we_o,
    output logic [DATA_W-1:0]         peri_wdata_o,
    output logic [DATA_W/8-1:0]       peri_be_o,
    input  logic [N_SLV-1:0]          peri_ack_i,
    input  logic [N_SLV*DATA_W-1:0]   peri_rdata_i,
    output logic [ADDR_W-1:0]         err_addr_o,
    output logic [7:0]                err_cnt_o
);

    // Handshake: req_valid_i and its fields are held stable until rsp_valid_o pulses
    // for one cycle; a request still valid in the cycle after the pulse is a new one.

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [N_SLV-1:0]  hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              ack_sel;
    logic [DATA_W-1:0] rdata_sel;
    logic              tmo_hit;

    // Descending scan so the lowest matching slot is the one left in hit_idx.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((req_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit[i]  = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ack_sel   = peri_ack_i[idx_q];
        rdata_sel = peri_rdata_i[idx_q*DATA_W +: DATA_W];
        // Fires on the TIMEOUT-th WAIT cycle, so sel_o is high for exactly TIMEOUT cycles.
        tmo_hit   = (TIMEOUT != 0) && ((int'(cnt_q) + 1) == TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
            sel_o        <= '0;
            peri_addr_o  <= '0;
            peri_we_o    <= 1'b0;
            peri_wdata_o <= '0;
            peri_be_o    <= '0;
            err_addr_o   <= '0;
            err_cnt_o    <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        if (|hit) begin
                            peri_addr_o  <= req_addr_i;
                            peri_we_o    <= req_we_i;
                            peri_wdata_o <= req_wdata_i;
                            peri_be_o    <= req_be_i;
                            idx_q        <= hit_idx;
                            sel_o        <= N_SLV'(1) << hit_idx;
                            cnt_q        <= '0;
                            state_q      <= ST_WAIT;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            err_addr_o  <= req_addr_i;
                            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        sel_o   <= '0;
                        state_q <= ST_IDLE;
                    end else if (ack_sel) begin
                        sel_o       <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= peri_we_o ? '0 : rdata_sel;
                        state_q     <= ST_RESP;
                    end else if (tmo_hit) begin
                        sel_o       <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        err_addr_o  <= peri_addr_o;
                        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                        state_q     <= ST_RESP;
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_xbar_n.sv
// Directed bench for dbus_xbar_n: 8 slots, slot i at i<<28, slots 1 and 3 overlap
// around 0x1000_0000; TIMEOUT=4 so the timeout path is reachable quickly.
`timescale 1ns/1ps
module tb_dbus_xbar_n;

    localparam int N = 8;
    localparam logic [N*32-1:0] BASE = {32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
                                        32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                                        32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic [31:0]     req_addr = '0;
    logic            req_we = 1'b0;
    logic [31:0]     req_wdata = '0;
    logic [3:0]      req_be = '0;
    logic            flush = 1'b0;
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [N-1:0]    sel;
    logic [31:0]     peri_addr;
    logic            peri_we;
    logic [31:0]     peri_wdata;
    logic [3:0]      peri_be;
    logic [N-1:0]    peri_ack = '0;
    logic [N*32-1:0] peri_rdata = '0;
    logic [31:0]     err_addr;
    logic [7:0]      err_cnt;

    int checks = 0;
    int failures = 0;

    dbus_xbar_n #(
        .N_SLV(N), .ADDR_W(32), .DATA_W(32),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_we_i(req_we),
        .req_wdata_i(req_wdata), .req_be_i(req_be), .flush_i(flush),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .sel_o(sel), .peri_addr_o(peri_addr), .peri_we_o(peri_we),
        .peri_wdata_o(peri_wdata), .peri_be_o(peri_be),
        .peri_ack_i(peri_ack), .peri_rdata_i(peri_rdata),
        .err_addr_o(err_addr), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wdata;
        req_be    = 4'hF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, sel, peri_addr, peri_we, peri_wdata, peri_be, err_addr, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rsp=%b rdata=%h err=%b sel=%h paddr=%h cnt=%0d exp all zero",
                     rsp_valid, rsp_rdata, rsp_err, sel, peri_addr, err_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_hit();
        issue(32'h2000_0010, 1'b0, 32'h0);
        tick();  // cycle 1
        checks++;
        if (sel !== 8'h04 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL read_c1 got sel=%h rsp=%b exp sel=04 rsp=0", sel, rsp_valid);
        end
        checks++;
        if (peri_addr !== 32'h2000_0010 || peri_we !== 1'b0 || peri_be !== 4'hF) begin
            failures++; $display("FAIL read_peri got addr=%h we=%b be=%h exp 20000010 0 f", peri_addr, peri_we, peri_be);
        end
        tick();  // cycle 2
        checks++;
        if (sel !== 8'h04 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL read_c2 got sel=%h rsp=%b exp sel=04 rsp=0", sel, rsp_valid);
        end
        peri_ack[2] = 1'b1;
        peri_rdata[2*32 +: 32] = 32'hDEAD_BEEF;
        tick();  // cycle 3
        peri_ack = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || sel !== 8'h00) begin
            failures++;
            $display("FAIL read_rsp got rsp=%b rdata=%h err=%b sel=%h exp 1 deadbeef 0 00", rsp_valid, rsp_rdata, rsp_err, sel);
        end
        req_valid = 1'b0;
        tick();  // cycle 4
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL read_after got rsp=%b rdata=%h exp 0 0", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_decode_error();
        issue(32'h9000_0000, 1'b1, 32'hA5A5_A5A5);
        tick();  // cycle 1
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || sel !== 8'h00 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL dec_rsp got rsp=%b err=%b sel=%h rdata=%h exp 1 1 00 0", rsp_valid, rsp_err, sel, rsp_rdata);
        end
        checks++;
        if (err_addr !== 32'h9000_0000 || err_cnt !== 8'd1) begin
            failures++; $display("FAIL dec_capture got addr=%h cnt=%0d exp 90000000 1", err_addr, err_cnt);
        end
        req_valid = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || sel !== 8'h00) begin
            failures++; $display("FAIL dec_after got rsp=%b sel=%h exp 0 00", rsp_valid, sel);
        end
    endtask

    task automatic test_timeout();
        issue(32'h4000_0000, 1'b0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (sel !== 8'h10 || rsp_valid !== 1'b0) begin
                failures++; $display("FAIL tmo_wait_c%0d got sel=%h rsp=%b exp 10 0", c, sel, rsp_valid);
            end
        end
        tick();  // cycle 5
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || sel !== 8'h00) begin
            failures++;
            $display("FAIL tmo_rsp got rsp=%b err=%b rdata=%h sel=%h exp 1 1 0 00", rsp_valid, rsp_err, rsp_rdata, sel);
        end
        checks++;
        if (err_cnt !== 8'd2 || err_addr !== 32'h4000_0000) begin
            failures++; $display("FAIL tmo_capture got cnt=%0d addr=%h exp 2 40000000", err_cnt, err_addr);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_ack_at_timeout();
        issue(32'h6000_0000, 1'b1, 32'h1234_5678);
        tick();  // cycle 1
        checks++;
        if (sel !== 8'h40 || peri_we !== 1'b1 || peri_wdata !== 32'h1234_5678) begin
            failures++; $display("FAIL ackt_c1 got sel=%h we=%b wdata=%h exp 40 1 12345678", sel, peri_we, peri_wdata);
        end
        tick();
        tick();
        tick();  // cycle 4: last WAIT cycle, timeout and ack coincide
        peri_ack[6] = 1'b1;
        peri_rdata[6*32 +: 32] = 32'hFFFF_FFFF;
        tick();  // cycle 5
        peri_ack = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || err_cnt !== 8'd2) begin
            failures++;
            $display("FAIL ackt_rsp got rsp=%b err=%b rdata=%h cnt=%0d exp 1 0 0 2", rsp_valid, rsp_err, rsp_rdata, err_cnt);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        issue(32'h5000_0000, 1'b0, 32'h0);
        tick();  // cycle 1
        tick();  // cycle 2: second WAIT cycle
        checks++;
        if (sel !== 8'h20) begin
            failures++; $display("FAIL flush_sel got sel=%h exp 20", sel);
        end
        flush = 1'b1;
        req_valid = 1'b0;
        tick();  // cycle 3
        flush = 1'b0;
        checks++;
        if (sel !== 8'h00 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL flush_abort got sel=%h rsp=%b exp 00 0", sel, rsp_valid);
        end
        peri_ack[5] = 1'b1;
        peri_rdata[5*32 +: 32] = 32'h0BAD_0BAD;
        tick();  // cycle 4: late ack ignored
        peri_ack = '0;
        checks++;
        if (rsp_valid !== 1'b0 || sel !== 8'h00) begin
            failures++; $display("FAIL flush_late_ack got rsp=%b sel=%h exp 0 00", rsp_valid, sel);
        end
        issue(32'h5000_0004, 1'b0, 32'h0);
        tick();
        checks++;
        if (sel !== 8'h20 || peri_addr !== 32'h5000_0004) begin
            failures++; $display("FAIL flush_next_sel got sel=%h addr=%h exp 20 50000004", sel, peri_addr);
        end
        peri_ack[5] = 1'b1;
        peri_rdata[5*32 +: 32] = 32'hCAFE_F00D;
        tick();
        peri_ack = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0) begin
            failures++; $display("FAIL flush_next_rsp got rsp=%b rdata=%h err=%b exp 1 cafef00d 0", rsp_valid, rsp_rdata, rsp_err);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_overlap();
        issue(32'h1000_0010, 1'b0, 32'h0);
        tick();  // cycle 1
        checks++;
        if (sel !== 8'h02) begin
            failures++; $display("FAIL ovl_sel got sel=%h exp 02", sel);
        end
        peri_ack[3] = 1'b1;
        peri_rdata[3*32 +: 32] = 32'h3333_3333;
        tick();  // cycle 2
        peri_ack = '0;
        checks++;
        if (sel !== 8'h02 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL ovl_ignore got sel=%h rsp=%b exp 02 0", sel, rsp_valid);
        end
        peri_ack[1] = 1'b1;
        peri_rdata[1*32 +: 32] = 32'h1111_2222;
        tick();  // cycle 3
        peri_ack = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1111_2222 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL ovl_rsp got rsp=%b rdata=%h err=%b exp 1 11112222 0", rsp_valid, rsp_rdata, rsp_err);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        issue(32'h2000_0020, 1'b0, 32'h0);
        tick();
        checks++;
        if (sel !== 8'h04) begin
            failures++; $display("FAIL rstw_sel got sel=%h exp 04", sel);
        end
        rst = 1'b1;
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (sel !== 8'h00 || rsp_valid !== 1'b0 || peri_addr !== 32'h0 || err_cnt !== 8'd0) begin
            failures++; $display("FAIL rstw_clear got sel=%h rsp=%b addr=%h cnt=%0d exp 00 0 0 0", sel, rsp_valid, peri_addr, err_cnt);
        end
        peri_ack[2] = 1'b1;
        tick();
        peri_ack = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rstw_norsp got rsp=%b exp 0", rsp_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back_saturate();
        int n_rsp;
        n_rsp = 0;
        issue(32'h9000_0000, 1'b0, 32'h0);
        for (int c = 1; c <= 519; c++) begin
            tick();
            if (rsp_valid === 1'b1) n_rsp++;
            if (c == 519) req_valid = 1'b0;
        end
        checks++;
        if (n_rsp != 260) begin
            failures++; $display("FAIL sat_rsp_count got %0d exp 260", n_rsp);
        end
        checks++;
        if (err_cnt !== 8'd255 || err_addr !== 32'h9000_0000) begin
            failures++; $display("FAIL sat_cnt got cnt=%0d addr=%h exp 255 90000000", err_cnt, err_addr);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, sel, peri_addr, peri_we, peri_wdata, peri_be, err_addr, err_cnt} !== '0) begin
            failures++;
            $display("FAIL sat_reset got rsp=%b sel=%h paddr=%h eaddr=%h cnt=%0d exp all zero",
                     rsp_valid, sel, peri_addr, err_addr, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_decode_error();
        test_timeout();
        test_ack_at_timeout();
        test_flush();
        test_overlap();
        test_reset_mid_wait();
        test_back_to_back_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
